// File: rtl/data_sram_bridge.sv
// Bridges the core's fixed-latency data SRAM port onto a req/addr_ok/data_ok bus and stalls the core.
// Define DATA_SRAM_BRIDGE_PERF_EN to add the handshake and stall performance counters.
module data_sram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_en,
  input  logic [3:0]  core_wen,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        req_wr_q;
  logic [1:0]  req_size_q;
  logic [31:0] req_addr_q, req_wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] timer_q, timer_d;
  logic        latch_req;
  logic        timeout_hit;
  logic        enc_wr;
  logic [1:0]  enc_size;
  logic [1:0]  enc_low;

  // Map byte enables to bus size and the low address bits of the first enabled lane.
  always_comb begin
    enc_wr   = |core_wen;
    enc_size = 2'd2;
    enc_low  = 2'b00;
    case (core_wen)
      4'b0011: begin enc_size = 2'd1; enc_low = 2'b00; end
      4'b1100: begin enc_size = 2'd1; enc_low = 2'b10; end
      4'b0001: begin enc_size = 2'd0; enc_low = 2'b00; end
      4'b0010: begin enc_size = 2'd0; enc_low = 2'b01; end
      4'b0100: begin enc_size = 2'd0; enc_low = 2'b10; end
      4'b1000: begin enc_size = 2'd0; enc_low = 2'b11; end
      default: begin enc_size = 2'd2; enc_low = 2'b00; end
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    latch_req  = 1'b0;
    core_stall = 1'b0;
    bus_req    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (core_en) begin
          latch_req  = 1'b1;
          core_stall = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        bus_req    = 1'b1;
        core_stall = 1'b1;
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            state_d = StDone;
            if (!req_wr_q) rdata_d = bus_rdata;
          end else begin
            state_d = StWait;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
          if (!req_wr_q) rdata_d = 32'hDEAD_BEEF;
        end
      end
      StWait: begin
        core_stall = 1'b1;
        if (bus_data_ok) begin
          state_d = StDone;
          if (!req_wr_q) rdata_d = bus_rdata;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
          if (!req_wr_q) rdata_d = 32'hDEAD_BEEF;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Keep the stall low while reset is held even if the core still shows an access.
    core_stall = core_stall & rst;
  end

  assign timer_d = (state_d != state_q) ? 32'd0 : timer_q + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      timer_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      if (latch_req) begin
        req_wr_q    <= enc_wr;
        req_size_q  <= enc_size;
        req_addr_q  <= {core_addr[31:2], enc_low};
        req_wdata_q <= core_wdata;
      end
    end
  end

  assign bus_wr     = req_wr_q;
  assign bus_size   = req_size_q;
  assign bus_addr   = req_addr_q;
  assign bus_wdata  = req_wdata_q;
  assign core_rdata = rdata_q;
  assign bus_err    = err_q;

`ifdef DATA_SRAM_BRIDGE_PERF_EN
  logic [31:0] perf_req_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_req_q   <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (bus_req && bus_addr_ok) perf_req_q <= perf_req_q + 32'd1;
      if (core_stall) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_req_cnt   = perf_req_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_req_cnt   = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: encoding table plus multi-cycle sequences.
// A second instance with TIMEOUT_CYCLES=4 shares the stimulus and covers the timeout path.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_en;
  logic [3:0]  core_wen;
  logic [31:0] core_addr, core_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  logic [31:0] core_rdata, bus_addr, bus_wdata, perf_req_cnt, perf_stall_cnt;
  logic        core_stall, bus_req, bus_wr, bus_err;
  logic [1:0]  bus_size;

  logic [31:0] t_core_rdata, t_bus_addr, t_bus_wdata, t_perf_req_cnt, t_perf_stall_cnt;
  logic        t_core_stall, t_bus_req, t_bus_wr, t_bus_err;
  logic [1:0]  t_bus_size;

  int n_total = 0;
  int n_bad   = 0;

  data_sram_bridge dut (
    .clk(clk), .rst(rst), .core_en(core_en), .core_wen(core_wen), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .perf_req_cnt(perf_req_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  data_sram_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .core_en(core_en), .core_wen(core_wen), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(t_core_rdata), .core_stall(t_core_stall),
    .bus_req(t_bus_req), .bus_wr(t_bus_wr), .bus_size(t_bus_size), .bus_addr(t_bus_addr),
    .bus_wdata(t_bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .bus_err(t_bus_err), .perf_req_cnt(t_perf_req_cnt),
    .perf_stall_cnt(t_perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] baddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
    core_en    = 1'b1;
    core_wen   = wen;
    core_addr  = addr;
    core_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int          stalls;
    logic [31:0] perf0;

    vecs[0] = '{4'h0, 32'h0000_0013, 32'h0, 32'hCAFE_F00D, 1'b0, 2'd2, 32'h10, 32'hCAFE_F00D};
    vecs[1] = '{4'hF, 32'h0000_0020, 32'h1122_3344, 32'h5555_5555, 1'b1, 2'd2, 32'h20,
                32'hCAFE_F00D};
    vecs[2] = '{4'h4, 32'h0000_0100, 32'h00AB_0000, 32'h5555_5555, 1'b1, 2'd0, 32'h102,
                32'hCAFE_F00D};
    vecs[3] = '{4'h1, 32'h0000_0303, 32'h0000_00CD, 32'h0, 1'b1, 2'd0, 32'h300, 32'hCAFE_F00D};
    vecs[4] = '{4'h2, 32'h0000_0040, 32'h0000_EF00, 32'h0, 1'b1, 2'd0, 32'h41, 32'hCAFE_F00D};
    vecs[5] = '{4'h8, 32'h0000_0040, 32'h7700_0000, 32'h0, 1'b1, 2'd0, 32'h43, 32'hCAFE_F00D};
    vecs[6] = '{4'h3, 32'h0000_0052, 32'h0000_BBCC, 32'h0, 1'b1, 2'd1, 32'h50, 32'hCAFE_F00D};
    vecs[7] = '{4'hC, 32'h0000_0050, 32'hDDEE_0000, 32'h0, 1'b1, 2'd1, 32'h52, 32'hCAFE_F00D};
    vecs[8] = '{4'h6, 32'h0000_0061, 32'h00AA_BB00, 32'h0, 1'b1, 2'd2, 32'h60, 32'hCAFE_F00D};
    vecs[9] = '{4'h0, 32'h7FFF_FFFF, 32'h0, 32'h0BAD_F00D, 1'b0, 2'd2, 32'h7FFF_FFFC,
                32'h0BAD_F00D};

    rst = 1'b0; core_en = 1'b0; core_wen = 4'h0; core_addr = 32'h0; core_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_wr", 32'(bus_wr), 0);
    chk("rst_bus_size", 32'(bus_size), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_core_stall", 32'(core_stall), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_perf_req", perf_req_cnt, 0);
    chk("rst_perf_stall", perf_stall_cnt, 0);
    rst = 1'b1;
    tick();

    // Encoding table: single-cycle handshake for each vector.
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk("tbl_idle_stall", 32'(core_stall), 1);
      tick();
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = vecs[i].rd;
      @(negedge clk);
      chk("tbl_bus_req", 32'(bus_req), 1);
      chk("tbl_bus_wr", 32'(bus_wr), 32'(vecs[i].wr));
      chk("tbl_bus_size", 32'(bus_size), 32'(vecs[i].size));
      chk("tbl_bus_addr", bus_addr, vecs[i].baddr);
      chk("tbl_bus_wdata", bus_wdata, vecs[i].wdata);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
      @(negedge clk);
      chk("tbl_done_stall", 32'(core_stall), 0);
      chk("tbl_core_rdata", core_rdata, vecs[i].exp_rdata);
      chk("tbl_bus_err", 32'(bus_err), 0);
      tick();
      core_en = 1'b0;
    end

    // Load: addr_ok on first REQ cycle, data_ok two cycles later.
    stalls = 0;
    start(4'h0, 32'h8000_1006, 32'h0);
    @(negedge clk);
    if (core_stall) stalls++;
    tick();
    bus_addr_ok = 1'b1;
    @(negedge clk);
    if (core_stall) stalls++;
    chk("ld_bus_req", 32'(bus_req), 1);
    chk("ld_bus_addr", bus_addr, 32'h8000_1004);
    chk("ld_bus_size", 32'(bus_size), 2);
    chk("ld_bus_wr", 32'(bus_wr), 0);
    tick();
    bus_addr_ok = 1'b0;
    @(negedge clk);
    if (core_stall) stalls++;
    chk("ld_wait_req", 32'(bus_req), 0);
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    if (core_stall) stalls++;
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("ld_done_stall", 32'(core_stall), 0);
    chk("ld_core_rdata", core_rdata, 32'h1234_5678);
    chk("ld_stall_cycles", 32'(stalls), 4);
    tick();
    core_en = 1'b0;
    @(negedge clk);
    chk("ld_idle_hold", core_rdata, 32'h1234_5678);
    tick();

    // Backpressure: addr_ok withheld for five REQ cycles.
    start(4'hF, 32'h0000_0400, 32'hA5A5_A5A5);
    perf0 = perf_req_cnt;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bus_req", 32'(bus_req), 1);
      chk("bp_bus_addr", bus_addr, 32'h400);
      chk("bp_stall", 32'(core_stall), 1);
      tick();
    end
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    @(negedge clk);
    chk("bp_wait_stall", 32'(core_stall), 1);
    chk("bp_wait_req", 32'(bus_req), 0);
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("bp_done_stall", 32'(core_stall), 0);
    chk("bp_core_rdata", core_rdata, 32'h1234_5678);
`ifdef DATA_SRAM_BRIDGE_PERF_EN
    chk("bp_perf_req", perf_req_cnt - perf0, 1);
`else
    chk("bp_perf_req", perf_req_cnt, 0);
`endif
    tick();
    core_en = 1'b0;

    // Stray data_ok in IDLE, then halfword store.
    bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stray_stall", 32'(core_stall), 0);
    chk("stray_req", 32'(bus_req), 0);
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("stray_rdata", core_rdata, 32'h1234_5678);
    chk("stray_idle_req", 32'(bus_req), 0);
    start(4'hC, 32'h0000_0200, 32'hBEEF_0000);
    tick();
    bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("hw_bus_size", 32'(bus_size), 1);
    chk("hw_bus_addr", bus_addr, 32'h202);
    chk("hw_bus_wr", 32'(bus_wr), 1);
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3333_3333;
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("hw_done_stall", 32'(core_stall), 0);
    chk("hw_core_rdata", core_rdata, 32'h1234_5678);
    tick();
    core_en = 1'b0;

    // Reset asserted mid-WAIT; a later data_ok must be ignored.
    start(4'h0, 32'h0000_0010, 32'h0);
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    @(negedge clk);
    chk("rw_wait_stall", 32'(core_stall), 1);
    rst = 1'b0;
    #1;
    chk("rw_bus_req", 32'(bus_req), 0);
    chk("rw_stall", 32'(core_stall), 0);
    chk("rw_core_rdata", core_rdata, 0);
    core_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("rw_late_req", 32'(bus_req), 0);
    chk("rw_late_stall", 32'(core_stall), 0);
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("rw_late_rdata", core_rdata, 0);
    chk("rw_late_idle", 32'(core_stall), 0);
    tick();

    // Timeout instance: load with no addr_ok.
    start(4'h0, 32'h0000_1000, 32'h0);
    @(negedge clk);
    chk("to_idle_stall", 32'(t_core_stall), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("to_req", 32'(t_bus_req), 1);
      chk("to_err_early", 32'(t_bus_err), 0);
    end
    tick();
    @(negedge clk);
    chk("to_err", 32'(t_bus_err), 1);
    chk("to_done_stall", 32'(t_core_stall), 0);
    chk("to_rdata", t_core_rdata, 32'hDEAD_BEEF);
    chk("to_done_req", 32'(t_bus_req), 0);
    tick();
    core_en = 1'b0;
    tick();
    start(4'h0, 32'h0000_2000, 32'h0);
    tick();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0102_0304;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("to_next_rdata", t_core_rdata, 32'h0102_0304);
    chk("to_err_sticky", 32'(t_bus_err), 1);
    tick();
    core_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the CPU core's data SRAM port, between the core and the SoC memory interconnect.
- Converts the core's fixed-latency data port (en/wen/addr/wdata, rdata expected next cycle) into a split-handshake sram-like bus (req/addr_ok/data_ok).
- Asserts a stall to the core's CTRL while a transaction is outstanding, and holds load data until the pipeline consumes it.

Parameters:
- TIMEOUT_CYCLES, 0, cycles to wait for addr_ok or data_ok before flagging an error; 0 disables the timeout.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- core_en  in  1  core data access valid (from EX).
- core_wen  in  4  byte write enables; 0 means load.
- core_addr  in  32  byte address.
- core_wdata  in  32  store data, already lane-aligned.
- core_rdata  out  32  load data, valid when core_stall=0 in DONE.
- core_stall  out  1  stall request to CTRL.
- bus_req  out  1  request valid.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_addr  out  32  request address.
- bus_wdata  out  32  write data.
- bus_addr_ok  in  1  request accepted this cycle.
- bus_data_ok  in  1  response (read data or write ack) this cycle.
- bus_rdata  in  32  read data, valid with data_ok.
- bus_err  out  1  sticky timeout flag.
- perf_req_cnt  out  32  see Optional Feature.
- perf_stall_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (rst=0, async): state=IDLE; bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0, core_rdata=0, core_stall=0, bus_err=0, counters=0.
- A reset mid-transaction drops bus_req immediately. Any later data_ok is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - core_en=1: latch wr, size, addr, wdata into request registers; go to REQ; core_stall=1 combinationally in the same cycle.
  - core_en=0: stay in IDLE.
- REQ:
  - bus_req=1; outputs driven from registers and stable until addr_ok.
  - addr_ok=1 and data_ok=0: go to WAIT.
  - addr_ok=1 and data_ok=1 in the same cycle: capture rdata (reads), go to DONE.
- WAIT:
  - bus_req=0.
  - data_ok=1: capture bus_rdata into core_rdata (reads only; writes leave core_rdata unchanged); go to DONE.
- DONE:
  - core_stall=0 for exactly one cycle, letting the pipeline advance; core_rdata held.
  - Always returns to IDLE. core_en in this cycle is ignored, because it still shows the completed access.
- core_stall is 1 in IDLE when core_en=1, and in REQ and WAIT; it is 0 otherwise.
- Minimum latency from core_en to release is 3 cycles (IDLE→REQ→DONE with addr_ok and data_ok together).
- Size and address encoding:
  - Loads: size=2, bus_addr=core_addr & ~3.
  - Stores with wen=1111: size=2, addr word-aligned.
  - Stores with wen=0011 or 1100: size=1, addr[1:0]=00 or 10.
  - Stores with a single-hot wen: size=0, addr[1:0]=index of the set bit.
  - Any other wen pattern: size=2, word-aligned; bus_err is not set.
- data_ok in IDLE or DONE is ignored.
- addr_ok outside REQ is ignored.
- Timeout (TIMEOUT_CYCLES>0):
  - A counter resets on each state entry.
  - Reaching TIMEOUT_CYCLES in REQ or WAIT sets bus_err (sticky until reset) and forces DONE with core_rdata=32'hDEADBEEF for reads.

Optional Feature:
- Macro DATA_SRAM_BRIDGE_PERF_EN.
- Defined:
  - perf_req_cnt increments on each REQ→accepted handshake (bus_req & bus_addr_ok).
  - perf_stall_cnt increments on each cycle core_stall=1.
  - Both are 32-bit, wrap from FFFFFFFF to 0, and reset to 0.
- Undefined: both ports are tied to 0; no counter flops are synthesized.

Test Plan:
- Load: core_en=1, wen=0, addr=0x8000_1006; addr_ok on the 1st REQ cycle, data_ok 2 cycles later with rdata=0x1234_5678 -> bus_addr=0x8000_1004, size=2, wr=0; stall for 4 cycles; core_rdata=0x1234_5678 in DONE.
- Byte store: wen=0100, addr=0x100, wdata=0x00AB_0000 -> size=0, bus_addr=0x102, wr=1; same-cycle addr_ok+data_ok -> REQ→DONE, core_rdata unchanged.
- Backpressure: addr_ok held 0 for 5 cycles -> bus_req and bus_addr stable for all 5 cycles; stall stays 1; exactly one handshake counted.
- Halfword store wen=1100, addr=0x200 -> size=1, bus_addr=0x202; a stray data_ok pulsed in IDLE beforehand has no effect.
- Reset mid-WAIT: rst=0 asserted -> bus_req=0, core_stall=0 immediately; a data_ok arriving after rst deasserts is ignored and the FSM stays in IDLE.
- TIMEOUT_CYCLES=4, load with no addr_ok -> bus_err=1 after 4 REQ cycles; DONE with core_rdata=0xDEADBEEF; bus_err remains 1 on subsequent accesses.
